// File: rtl/haar_filter_bank_mc.sv
// Time-multiplexed multi-channel Haar analysis bank: one shared add/sub engine walks the stage cascade.
// Optional HAAR_ROUND_EN: round half toward +inf before the >>>1 instead of flooring.
module haar_filter_bank_mc #(
  parameter int STAGES         = 4,
  parameter int CHANNELS       = 2,
  parameter int IN_WIDTH       = 16,
  parameter int INTERNAL_WIDTH = 18,
  parameter int OUT_WIDTH      = 16,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LEVEL_W = ($clog2(STAGES + 1) > 1) ? $clog2(STAGES + 1) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [CHAN_W-1:0]           inChan,
  input  logic signed [IN_WIDTH-1:0]  dataIn,
  output logic                        outValid,
  output logic [CHAN_W-1:0]           outChan,
  output logic [LEVEL_W-1:0]          outLevel,
  output logic signed [OUT_WIDTH-1:0] dataOut,
  output logic                        overflow
);
  localparam int IW = INTERNAL_WIDTH;
  localparam logic signed [IW:0] OUT_MAX = (IW+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [IW:0] OUT_MIN = -OUT_MAX - (IW+1)'(1);
`ifdef HAAR_ROUND_EN
  localparam logic signed [IW+1:0] RND = (IW+2)'(1);
`else
  localparam logic signed [IW+1:0] RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, EMIT_LOW} state_t;

  state_t                   state_q, state_d;
  logic [CHAN_W-1:0]        ch_q, ch_d;
  logic [LEVEL_W-1:0]       s_q, s_d;
  logic signed [IW-1:0]     opnd_q, opnd_d;
  logic                     phase_q [CHANNELS][STAGES];
  logic signed [IW-1:0]     prev_q  [CHANNELS][STAGES];
  logic                     out_valid_q, out_valid_d;
  logic [CHAN_W-1:0]        out_chan_q, out_chan_d;
  logic [LEVEL_W-1:0]       out_level_q, out_level_d;
  logic signed [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                     ovf_q, ovf_d;

  logic                     sel_phase;
  logic signed [IW-1:0]     sel_prev;
  logic signed [IW+1:0]     a_ext, b_ext, sum, diff;
  logic signed [IW-1:0]     low_v, high_v, emit_v;
  logic signed [IW:0]       emit_ext;
  logic signed [OUT_WIDTH-1:0] sat_v;
  logic                     sat_ovf;
  logic                     phase_wr, phase_val, prev_wr;

  always_comb begin
    sel_phase = 1'b0;
    sel_prev  = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int s = 0; s < STAGES; s++)
        if (ch_q == CHAN_W'(c) && s_q == LEVEL_W'(s)) begin
          sel_phase = phase_q[c][s];
          sel_prev  = prev_q[c][s];
        end
  end

  // Extra headroom bit keeps the rounded difference from wrapping before the halving.
  always_comb begin
    a_ext    = (IW+2)'(sel_prev);
    b_ext    = (IW+2)'(opnd_q);
    sum      = a_ext + b_ext + RND;
    diff     = a_ext - b_ext + RND;
    low_v    = IW'(sum >>> 1);
    high_v   = IW'(diff >>> 1);
    emit_v   = (state_q == EMIT_LOW) ? opnd_q : high_v;
    emit_ext = (IW+1)'(emit_v);
    sat_ovf  = 1'b0;
    if (emit_ext > OUT_MAX) begin
      sat_v   = OUT_WIDTH'(OUT_MAX);
      sat_ovf = 1'b1;
    end else if (emit_ext < OUT_MIN) begin
      sat_v   = OUT_WIDTH'(OUT_MIN);
      sat_ovf = 1'b1;
    end else begin
      sat_v = OUT_WIDTH'(emit_v);
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    s_d         = s_q;
    opnd_d      = opnd_q;
    phase_wr    = 1'b0;
    phase_val   = 1'b0;
    prev_wr     = 1'b0;
    out_valid_d = 1'b0;
    out_chan_d  = out_chan_q;
    out_level_d = out_level_q;
    data_out_d  = data_out_q;
    ovf_d       = ovf_q;
    inReady     = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (inValid && (int'(inChan) < CHANNELS)) begin
          ch_d    = inChan;
          opnd_d  = IW'(dataIn);
          s_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        phase_wr = 1'b1;
        if (!sel_phase) begin
          phase_val = 1'b1;
          prev_wr   = 1'b1;
          state_d   = IDLE;
        end else begin
          out_valid_d = 1'b1;
          out_chan_d  = ch_q;
          out_level_d = LEVEL_W'(STAGES) - s_q;
          data_out_d  = sat_v;
          ovf_d       = ovf_q | sat_ovf;
          opnd_d      = low_v;
          if (s_q == LEVEL_W'(STAGES - 1)) state_d = EMIT_LOW;
          else s_d = s_q + 1'b1;
        end
      end
      EMIT_LOW: begin
        out_valid_d = 1'b1;
        out_chan_d  = ch_q;
        out_level_d = '0;
        data_out_d  = sat_v;
        ovf_d       = ovf_q | sat_ovf;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      s_q         <= '0;
      opnd_q      <= '0;
      phase_q     <= '{default: '0};
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_level_q <= '0;
      data_out_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      s_q         <= s_d;
      opnd_q      <= opnd_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_level_q <= out_level_d;
      data_out_q  <= data_out_d;
      ovf_q       <= ovf_d;
      if (phase_wr)
        for (int c = 0; c < CHANNELS; c++)
          for (int s = 0; s < STAGES; s++)
            if (ch_q == CHAN_W'(c) && s_q == LEVEL_W'(s)) phase_q[c][s] <= phase_val;
    end
  end

  // Sample storage needs no reset: a cleared phase bit marks it as stale.
  always_ff @(posedge clk) begin
    if (prev_wr)
      for (int c = 0; c < CHANNELS; c++)
        for (int s = 0; s < STAGES; s++)
          if (ch_q == CHAN_W'(c) && s_q == LEVEL_W'(s)) prev_q[c][s] <= opnd_q;
  end

  assign outValid = out_valid_q;
  assign outChan  = out_chan_q;
  assign outLevel = out_level_q;
  assign dataOut  = data_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_haar_filter_bank_mc.sv
// Directed bench for haar_filter_bank_mc (STAGES=2, CHANNELS=2, OUT_WIDTH=8); honours HAAR_ROUND_EN.
module tb_haar_filter_bank_mc;
  localparam int STAGES = 2;
`ifdef HAAR_ROUND_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  logic clk = 1'b0;
  logic rst, inValid, inReady, outValid, overflow;
  logic [0:0] inChan, outChan;
  logic [1:0] outLevel;
  logic signed [15:0] dataIn;
  logic signed [7:0] dataOut;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  haar_filter_bank_mc #(
    .STAGES(STAGES), .CHANNELS(2), .IN_WIDTH(16), .INTERNAL_WIDTH(18), .OUT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inChan(inChan),
    .dataIn(dataIn), .outValid(outValid), .outChan(outChan), .outLevel(outLevel),
    .dataOut(dataOut), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int v);
    inValid = 1'b1;
    inChan  = 1'(ch);
    dataIn  = 16'(v);
    chk("ready_at_send", inReady, 1);
    cyc();
    inValid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int ch, input int lvl, input int val);
    chk({tag, "_valid"}, outValid, 1);
    chk({tag, "_chan"}, outChan, ch);
    chk({tag, "_level"}, outLevel, lvl);
    chk({tag, "_data"}, dataOut, val);
  endtask

  task automatic expect_none(input string tag);
    chk(tag, outValid, 0);
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference model state for the back-to-back section
  int m_ph [2][2];
  int m_prev [2][2];
  logic ev [0:99];
  int ec [0:99];
  int el [0:99];
  int ed [0:99];
  int sc [10] = '{0, 0, 1, 1, 0, 1, 0, 1, 0, 0};
  int sv [10] = '{10, 4, 100, -50, 6, 30, 2, 20, 500, -500};
  int idx, ready_after;

  initial begin
    rst = 1'b1; inValid = 1'b0; inChan = '0; dataIn = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", outValid, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_chan", outChan, 0);
    chk("rst_level", outLevel, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", inReady, 1);

    // first pair: only the stage-0 HPF
    send(0, 10);
    chk("busy_ready", inReady, 0);
    expect_none("t1_accept");
    cyc(); expect_none("t1_store");
    send(0, 4); expect_none("t1_accept2");
    cyc(); expect_out("t1_l2", 0, 2, 3);
    cyc(); expect_none("t1_no_l1");
    chk("t1_ready", inReady, 1);

    // second pair completes the cascade
    send(0, 6); cyc(); expect_none("t2_store");
    send(0, 2);
    cyc(); expect_out("t2_l2", 0, 2, 2);
    cyc(); expect_out("t2_l1", 0, 1, R ? 2 : 1);
    chk("t2_emit_ready", inReady, 0);
    cyc(); expect_out("t2_l0", 0, 0, R ? 6 : 5);
    cyc(); expect_none("t2_after");

    // channel interleave
    send(0, 10); cyc();
    send(1, 100); cyc();
    send(0, 4); cyc(); expect_out("t3_ch0_l2", 0, 2, 3);
    cyc(); expect_none("t3_ch0_store");
    send(1, 50); cyc(); expect_out("t3_ch1_l2", 1, 2, 25);
    cyc(); expect_none("t3_ch1_store");

    // saturation and sticky overflow
    chk("t4_ovf_before", overflow, 0);
    send(0, 1000); cyc();
    send(0, -1000);
    cyc(); expect_out("t4_l2", 0, 2, 127);
    chk("t4_ovf_set", overflow, 1);
    cyc(); expect_out("t4_l1", 0, 1, R ? 4 : 3);
    cyc(); expect_out("t4_l0", 0, 0, R ? 4 : 3);
    chk("t4_ovf_sticky", overflow, 1);
    cyc(); chk("t4_ovf_hold", overflow, 1);

    // reset in the middle of a walk
    send(1, 20); cyc();
    send(1, 10);
    cyc(); expect_out("t5_l2", 1, 2, 5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_rst_valid", outValid, 0);
    chk("t5_rst_ovf", overflow, 0);
    chk("t5_rst_data", dataOut, 0);
    chk("t5_rst_level", outLevel, 0);
    cyc(); expect_none("t5_quiet1");
    cyc(); expect_none("t5_quiet2");
    send(1, 8); cyc();
    send(1, 2);
    cyc(); expect_out("t5_pair_l2", 1, 2, 3);
    cyc(); expect_none("t5_no_l1");
    cyc(); expect_none("t5_no_l0");

    // inValid held high throughout, compared against the model
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 2; s++) begin
        m_ph[c][s] = 0;
        m_prev[c][s] = 0;
      end
    for (int i = 0; i < 100; i++) begin
      ev[i] = 1'b0; ec[i] = 0; el[i] = 0; ed[i] = 0;
    end
    idx = 0;
    ready_after = 0;
    for (int n = 0; n < 60; n++) begin
      inValid = (idx < 10);
      if (idx < 10) begin
        inChan = 1'(sc[idx]);
        dataIn = 16'(sv[idx]);
      end
      chk("cont_ready", inReady, (n >= ready_after) ? 1 : 0);
      chk("cont_valid", outValid, ev[n]);
      if (ev[n]) begin
        chk("cont_chan", outChan, ec[n]);
        chk("cont_level", outLevel, el[n]);
        chk("cont_data", dataOut, ed[n]);
      end
      if (idx < 10 && n >= ready_after) begin
        int c, op, s, a, hi, lo, t;
        bit done;
        t = n + 1;
        c = sc[idx];
        op = sv[idx];
        s = 0;
        done = 1'b0;
        while (!done) begin
          if (m_ph[c][s] == 0) begin
            m_prev[c][s] = op;
            m_ph[c][s] = 1;
            ready_after = t + s + 1;
            done = 1'b1;
          end else begin
            a = m_prev[c][s];
            hi = (a - op + R) >>> 1;
            lo = (a + op + R) >>> 1;
            m_ph[c][s] = 0;
            ev[t+s+1] = 1'b1; ec[t+s+1] = c; el[t+s+1] = STAGES - s; ed[t+s+1] = sat8(hi);
            if (s == STAGES - 1) begin
              ev[t+STAGES+1] = 1'b1; ec[t+STAGES+1] = c; el[t+STAGES+1] = 0;
              ed[t+STAGES+1] = sat8(lo);
              ready_after = t + STAGES + 1;
              done = 1'b1;
            end else begin
              op = lo;
              s++;
            end
          end
        end
        idx++;
      end
      cyc();
    end
    inValid = 1'b0;
    chk("cont_end_ready", inReady, 1);
    chk("cont_end_valid", outValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
